// File: rtl/seq_multiplier.sv
// Iterative 32x32 shift-add multiplier for the RV32 M multiply group.
// One product bit per cycle through the shared ripple-carry adder; fixed 34-cycle latency.
module seq_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_MUL,
        S_FIX
    } state_t;

    state_t      state, state_next;
    logic [1:0]  opcode;
    logic        sign_fix;
    logic [31:0] mcand;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [5:0]  cnt;

    logic        a_signed;
    logic        b_signed;
    logic [31:0] addend;
    logic [32:0] sum_carry;
    logic [63:0] product;
    logic [63:0] fixed;

    assign a_signed  = (opcode == 2'b01) || (opcode == 2'b10);
    assign b_signed  = (opcode == 2'b01);
    assign addend    = lo[0] ? mcand : 32'd0;
    assign sum_carry = {1'b0, hi} + {1'b0, addend};
    assign product   = {hi, lo};
    assign fixed     = sign_fix ? (~product + 64'd1) : product;

    assign ready_o = (state == S_IDLE);
    assign busy_o  = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_i) state_next = S_PREP;
            S_PREP:  state_next = S_MUL;
            S_MUL:   if (cnt == 6'd31) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (kill_i && state != S_IDLE) begin
            state_next = S_IDLE;
        end
    end

    // Operands are latched straight into mcand/lo and converted to magnitudes in place during PREP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode   <= 2'b00;
            sign_fix <= 1'b0;
            mcand    <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            cnt      <= 6'd0;
            result_o <= 32'd0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (!(kill_i && state != S_IDLE)) begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            opcode <= op_i;
                            mcand  <= a_i;
                            lo     <= b_i;
                        end
                    end
                    S_PREP: begin
                        mcand    <= (a_signed && mcand[31]) ? (~mcand + 32'd1) : mcand;
                        lo       <= (b_signed && lo[31]) ? (~lo + 32'd1) : lo;
                        sign_fix <= (a_signed & mcand[31]) ^ (b_signed & lo[31]);
                        hi       <= 32'd0;
                        cnt      <= 6'd0;
                    end
                    S_MUL: begin
                        {hi, lo} <= {sum_carry, lo[31:1]};
                        cnt      <= cnt + 6'd1;
                    end
                    S_FIX: begin
                        result_o <= (opcode == 2'b00) ? fixed[31:0] : fixed[63:32];
                        done_o   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed M-extension cases, handshake timing,
// kill/reset behaviour, and random operands against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        kill_i;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int  check_count = 0;
    int  pass_count  = 0;
    time acc_time;
    time done_time;
    time prev_done_time;
    int  lat;
    logic [31:0] last_result;

    seq_multiplier dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .kill_i   (kill_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full 64-bit product from sign/zero-extended operands, then pick the requested word.
    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (!ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) checkOutput("ready_wait", {63'd0, ready_o}, 64'd1);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        acc_time = $time;
        #1;
        start_i = 1'b0;
    endtask

    task automatic waitDone(output int latency);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!done_o && guard < 100);
        if (!done_o) checkOutput("done_timeout", {63'd0, done_o}, 64'd1);
        done_time = $time;
        latency   = int'(($time - acc_time - 5) / 10);
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int l;
        applyStimulus(op, a, b);
        waitDone(l);
        checkOutput({tag, "_result"}, {32'd0, result_o}, {32'd0, exp});
        checkOutput({tag, "_latency"}, l, 34);
        last_result = exp;
    endtask

    initial begin
        int seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] specials [4];
        specials[0] = 32'h80000000;
        specials[1] = 32'hFFFFFFFF;
        specials[2] = 32'h00000000;
        specials[3] = 32'h7FFFFFFF;

        rst_n   = 1'b0;
        start_i = 1'b0;
        op_i    = 2'b00;
        a_i     = 32'd0;
        b_i     = 32'd0;
        kill_i  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready",  {63'd0, ready_o}, 64'd1);
        checkOutput("rst_busy",   {63'd0, busy_o},  64'd0);
        checkOutput("rst_done",   {63'd0, done_o},  64'd0);
        checkOutput("rst_result", {32'd0, result_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First op checked in detail: busy/ready flip and a single-cycle done pulse.
        applyStimulus(2'b00, 32'd7, 32'd6);
        @(negedge clk);
        checkOutput("busy_after_start",  {63'd0, busy_o},  64'd1);
        checkOutput("ready_after_start", {63'd0, ready_o}, 64'd0);
        waitDone(lat);
        checkOutput("mul7x6_result", {32'd0, result_o}, 64'h2A);
        checkOutput("mul7x6_latency", lat, 34);
        checkOutput("ready_with_done", {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        checkOutput("done_single_pulse", {63'd0, done_o}, 64'd0);
        checkOutput("result_held", {32'd0, result_o}, 64'h2A);

        runOp("mulhu_ff",   2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        runOp("mul_ff",     2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        runOp("mulh_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        runOp("mulh_neg3",  2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF);
        runOp("mul_neg3",   2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1);
        runOp("mulhsu_m1",  2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        runOp("mulhu_m1",   2'b11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);

        // A start pulse mid-operation must not disturb the accepted operands.
        applyStimulus(2'b00, 32'd7, 32'd6);
        repeat (5) @(negedge clk);
        start_i = 1'b1;
        op_i    = 2'b11;
        a_i     = 32'hFFFFFFFF;
        b_i     = 32'hFFFFFFFF;
        @(negedge clk);
        start_i = 1'b0;
        waitDone(lat);
        checkOutput("busy_start_result", {32'd0, result_o}, 64'h2A);
        checkOutput("busy_start_latency", lat, 34);
        prev_done_time = done_time;

        // Start issued in the done cycle: next result exactly 35 cycles later.
        applyStimulus(2'b00, 32'd9, 32'd9);
        waitDone(lat);
        checkOutput("b2b_result", {32'd0, result_o}, 64'd81);
        checkOutput("b2b_spacing", int'((done_time - prev_done_time) / 10), 35);
        last_result = 32'd81;
        @(negedge clk);

        applyStimulus(2'b11, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        checkOutput("kill_ready", {63'd0, ready_o}, 64'd1);
        checkOutput("kill_busy",  {63'd0, busy_o},  64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        checkOutput("kill_no_done", seen, 0);
        checkOutput("kill_result_kept", {32'd0, result_o}, {32'd0, last_result});

        applyStimulus(2'b01, 32'hDEADBEEF, 32'h01234567);
        repeat (15) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ready",  {63'd0, ready_o}, 64'd1);
        checkOutput("async_rst_busy",   {63'd0, busy_o},  64'd0);
        checkOutput("async_rst_result", {32'd0, result_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp("mul3x4", 2'b00, 32'd3, 32'd4, 32'h0000000C);

        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            runOp($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, refModel(rop, ra, rb));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative 32×32 shift-add multiplier for the RV32 M-extension multiply group (MUL, MULH, MULHSU, MULHU). It sits directly upstream of the 32-bit ripple-carry adder: each cycle it presents the running partial-product high word and the multiplicand to the adder, then shifts in the sum and carry-out. It returns one 32-bit result per request to the execute stage with a fixed latency, and uses start/done handshaking.

## Interface
- Parameters: none. Width is fixed at 32.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  request strobe; accepted only while ready_o=1.
- op_i  in  2  operation select: 00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- a_i  in  32  rs1 operand; signed for MULH and MULHSU.
- b_i  in  32  rs2 operand; signed for MULH only.
- kill_i  in  1  synchronous abort, e.g. on pipeline flush.
- ready_o  out  1  high in IDLE only.
- busy_o  out  1  high in PREP, MUL and FIX.
- done_o  out  1  one-cycle pulse when result_o is updated.
- result_o  out  32  selected product word; held until the next done_o.

## Operation
- Registers:
  - opcode latch.
  - sign_fix flag.
  - mcand: 32-bit multiplicand.
  - hi: 32-bit running high word.
  - lo: 32-bit multiplier, shifting right.
  - cnt: 6-bit iteration counter.
  - result_o.
- Adder datapath: the existing 32-bit ripple-carry adder, with inputs hi and (lo[0] ? mcand : 0). Carry-in is 0. Outputs are sum and carry.
- State machine:
  - IDLE: on start_i=1, latch a_i, b_i, op_i, and go to PREP. Otherwise stay.
  - PREP: replace each signed-interpreted operand with its magnitude (two's-complement negate if bit 31=1). Compute sign_fix = sign(a) XOR sign(b), using signs only where op treats the operand as signed. Load mcand=|a|, lo=|b|, hi=0, cnt=0. Go to MUL.
  - MUL: each cycle, {hi, lo} ← {carry, sum, lo[31:1]} and cnt ← cnt+1. After the iteration where cnt=31, go to FIX.
  - FIX: if sign_fix, negate the 64-bit {hi, lo}. Register result_o = lo for MUL, hi otherwise. Assert done_o and go to IDLE.
- Magnitude of 0x80000000 is 2^31 and is represented correctly as unsigned. No overflow case exists.
- MUL low word is sign-independent. op 00 must equal the low word of MULHU for identical operands.
- start_i while busy_o=1 is ignored: no queuing, and latched operands are unaffected.
- kill_i (any non-IDLE state): next state is IDLE. No done_o, and result_o is unchanged. kill_i in IDLE has no effect. If kill_i and start_i are both high in IDLE, the start is accepted.
- Reset (any time, including mid-operation): state=IDLE; ready_o=1; busy_o=0; done_o=0; result_o=0; all internal registers are 0.

## Timing
- Start accepted at rising edge k:
  - PREP during cycle k→k+1.
  - MUL iterations at edges k+2 … k+33 (32 edges).
  - FIX registers the result at edge k+34.
- done_o is high for exactly one cycle after edge k+34. result_o is valid from that same cycle.
- Fixed latency: 34 cycles from accepting edge to done_o. This is independent of operand values and op.
- ready_o falls after edge k and rises after edge k+34, so done_o and ready_o are high together. A new start_i in the done_o cycle is accepted at edge k+35, giving back-to-back throughput of one result per 35 cycles.
- busy_o covers edges k+1 … k+34 inclusive of the state outputs, i.e. it is high exactly when ready_o is low.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then MUL a=7, b=6. Expect result_o=0x0000002A, done_o 34 cycles after start, single pulse.
- MULHU 0xFFFFFFFF×0xFFFFFFFF. Expect 0xFFFFFFFE. The same operands with MUL give 0x00000001.
- Signed handling:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULH 0xFFFFFFFD×0x00000005 → 0xFFFFFFFF; the same operands with MUL → 0xFFFFFFF1.
- MULHSU 0xFFFFFFFF×0x00000002. Expect 0xFFFFFFFF, since -2 is sign-extended. Then MULHU with the same operands: expect 0x00000001.
- Pulse start_i with new operands at cycle 5 of a busy operation: the original result is unaffected. Issue a start in the done_o cycle: the next done_o arrives exactly 35 cycles after the previous one.
- Abort and reset:
  - Assert kill_i at cycle 10 of an operation: state returns to IDLE, no done_o, and result_o keeps its previous value.
  - Deassert rst_n (asynchronously) mid-MUL: ready_o=1, busy_o=0, result_o=0 immediately.
  - A subsequent MUL 3×4 gives 0x0000000C.
